control_unit: RTL and testbench

//  Main decoder of the single-cycle MIPS CPU. Sits between the instruction memory and the datapath.

---
 rtl/control_unit.sv | 177 +++++++++++++++++
 tb/tb_control_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Main instruction decoder for the single-cycle MIPS core.
// Decode is combinational; the only state is the latched interrupt request.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        IRQ,
  input  logic        Supervise,
  output logic [2:0]  PCSrc,
  output logic [1:0]  RegDst,
  output logic        RegWr,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic        MemRd,
  output logic        MemWr,
  output logic [1:0]  MemToReg,
  output logic        EXTOp,
  output logic        LUOp
);

  typedef struct packed {
    logic [2:0] pcsrc;
    logic [1:0] regdst;
    logic       regwr;
    logic       alusrc1;
    logic       alusrc2;
    logic [5:0] alufun;
    logic       sign;
    logic       memrd;
    logic       memwr;
    logic [1:0] memtoreg;
    logic       extop;
    logic       luop;
  } ctrl_t;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  logic [5:0] op, funct;
  logic       irq_pend_q, irq_pend_d;
  logic       legal, take_irq, take_ill;
  ctrl_t      dec, ctrl;

  assign op    = instruction[31:26];
  assign funct = instruction[5:0];

  // Register/immediate fields are consumed by the datapath, not the decoder.
  logic unused_fields;
  assign unused_fields = ^instruction[25:6];

  // A request seen in kernel mode is held until the core leaves kernel mode.
  always_comb irq_pend_d = IRQ | (irq_pend_q & Supervise);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_pend_q <= 1'b0;
    else       irq_pend_q <= irq_pend_d;
  end

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (op)
      6'h00: begin
        dec.regwr = 1'b1;
        case (funct)
          6'h20: begin dec.alufun = ALU_ADD; dec.sign = 1'b1; end
          6'h21: dec.alufun = ALU_ADD;
          6'h22: begin dec.alufun = ALU_SUB; dec.sign = 1'b1; end
          6'h23: dec.alufun = ALU_SUB;
          6'h24: dec.alufun = ALU_AND;
          6'h25: dec.alufun = ALU_OR;
          6'h26: dec.alufun = ALU_XOR;
          6'h27: dec.alufun = ALU_NOR;
          6'h2A: begin dec.alufun = ALU_LT; dec.sign = 1'b1; end
          6'h2B: dec.alufun = ALU_LT;
          6'h00: begin dec.alufun = ALU_SLL; dec.alusrc1 = 1'b1; end
          6'h02: begin dec.alufun = ALU_SRL; dec.alusrc1 = 1'b1; end
          6'h03: begin dec.alufun = ALU_SRA; dec.alusrc1 = 1'b1; end
          6'h08: begin dec.pcsrc = 3'd3; dec.regwr = 1'b0; end
          6'h09: begin dec.pcsrc = 3'd3; dec.memtoreg = 2'd2; end
          default: legal = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h23, 6'h2B: begin
        dec.alusrc2 = 1'b1;
        dec.regdst  = 2'd1;
        dec.regwr   = 1'b1;
        case (op)
          6'h08: begin dec.alufun = ALU_ADD; dec.extop = 1'b1; dec.sign = 1'b1; end
          6'h09: begin dec.alufun = ALU_ADD; dec.extop = 1'b1; end
          6'h0A: begin dec.alufun = ALU_LT;  dec.extop = 1'b1; dec.sign = 1'b1; end
          6'h0B: begin dec.alufun = ALU_LT;  dec.extop = 1'b1; end
          6'h0C: dec.alufun = ALU_AND;
          6'h0F: begin dec.alufun = ALU_ADD; dec.luop = 1'b1; end
          6'h23: begin
            dec.alufun   = ALU_ADD;
            dec.extop    = 1'b1;
            dec.memrd    = 1'b1;
            dec.memtoreg = 2'd1;
          end
          default: begin
            dec.alufun = ALU_ADD;
            dec.extop  = 1'b1;
            dec.memwr  = 1'b1;
            dec.regwr  = 1'b0;
          end
        endcase
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        dec.pcsrc = 3'd1;
        dec.extop = 1'b1;
        dec.sign  = 1'b1;
        case (op)
          6'h04:   dec.alufun = ALU_EQ;
          6'h05:   dec.alufun = ALU_NEQ;
          6'h06:   dec.alufun = ALU_LEZ;
          6'h07:   dec.alufun = ALU_GTZ;
          default: dec.alufun = ALU_LTZ;
        endcase
      end
      6'h02: dec.pcsrc = 3'd2;
      6'h03: begin
        dec.pcsrc    = 3'd2;
        dec.regdst   = 2'd2;
        dec.regwr    = 1'b1;
        dec.memtoreg = 2'd2;
      end
      default: legal = 1'b0;
    endcase
  end

  assign take_irq = irq_pend_q & ~Supervise;
  assign take_ill = ~Supervise & ~legal;

  // Traps save PC+4 into $k0; in kernel mode an unknown opcode is a NOP.
  always_comb begin
    ctrl = dec;
    if (take_irq || take_ill) begin
      ctrl          = '0;
      ctrl.pcsrc    = take_irq ? 3'd5 : 3'd4;
      ctrl.regdst   = 2'd3;
      ctrl.regwr    = 1'b1;
      ctrl.memtoreg = 2'd2;
    end else if (!legal) begin
      ctrl = '0;
    end
  end

  assign PCSrc    = ctrl.pcsrc;
  assign RegDst   = ctrl.regdst;
  assign RegWr    = ctrl.regwr;
  assign ALUSrc1  = ctrl.alusrc1;
  assign ALUSrc2  = ctrl.alusrc2;
  assign ALUFun   = ctrl.alufun;
  assign Sign     = ctrl.sign;
  assign MemRd    = ctrl.memrd;
  assign MemWr    = ctrl.memwr;
  assign MemToReg = ctrl.memtoreg;
  assign EXTOp    = ctrl.extop;
  assign LUOp     = ctrl.luop;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a table-driven decode model plus an
// interrupt-pending model feed an expected queue checked by a monitor.
module tb_control_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        IRQ = 1'b0, Supervise = 1'b0;
  logic [2:0]  PCSrc;
  logic [1:0]  RegDst, MemToReg;
  logic        RegWr, ALUSrc1, ALUSrc2, Sign, MemRd, MemWr, EXTOp, LUOp;
  logic [5:0]  ALUFun;

  control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction), .IRQ(IRQ),
    .Supervise(Supervise), .PCSrc(PCSrc), .RegDst(RegDst), .RegWr(RegWr),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUFun(ALUFun), .Sign(Sign),
    .MemRd(MemRd), .MemWr(MemWr), .MemToReg(MemToReg), .EXTOp(EXTOp),
    .LUOp(LUOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] pcsrc;
    logic [1:0] regdst;
    logic       regwr, a1, a2;
    logic [5:0] fun;
    logic       sign, mrd, mwr;
    logic [1:0] m2r;
    logic       ext, lu;
  } exp_t;

  typedef struct {
    exp_t        e;
    logic [31:0] ins;
    int          id;
  } item_t;

  item_t q[$];
  int    tests = 0, fails = 0, issued = 0;

  exp_t rtab[64], itab[64];
  bit   rok[64], iok[64];

  // model state: pending-interrupt flag and inputs seen at the last edge
  bit pend = 0, prev_irq = 0, prev_sup = 0, prev_rst = 1;

  function automatic exp_t mk(int pc, int rd, bit rw, bit a1, bit a2, logic [5:0] f,
                              bit s, bit mr, bit mw, int m2r, bit ex, bit lu);
    exp_t e;
    e.pcsrc = 3'(pc); e.regdst = 2'(rd); e.regwr = rw; e.a1 = a1; e.a2 = a2;
    e.fun = f; e.sign = s; e.mrd = mr; e.mwr = mw; e.m2r = 2'(m2r);
    e.ext = ex; e.lu = lu;
    return e;
  endfunction

  task automatic r_ent(int fn, exp_t e); rtab[fn] = e; rok[fn] = 1; endtask
  task automatic i_ent(int o, exp_t e);  itab[o] = e;  iok[o] = 1;  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin rok[k] = 0; iok[k] = 0; end
    r_ent('h20, mk(0,0,1,0,0,6'b000000,1,0,0,0,0,0));
    r_ent('h21, mk(0,0,1,0,0,6'b000000,0,0,0,0,0,0));
    r_ent('h22, mk(0,0,1,0,0,6'b000001,1,0,0,0,0,0));
    r_ent('h23, mk(0,0,1,0,0,6'b000001,0,0,0,0,0,0));
    r_ent('h24, mk(0,0,1,0,0,6'b011000,0,0,0,0,0,0));
    r_ent('h25, mk(0,0,1,0,0,6'b011110,0,0,0,0,0,0));
    r_ent('h26, mk(0,0,1,0,0,6'b010110,0,0,0,0,0,0));
    r_ent('h27, mk(0,0,1,0,0,6'b010001,0,0,0,0,0,0));
    r_ent('h2A, mk(0,0,1,0,0,6'b110101,1,0,0,0,0,0));
    r_ent('h2B, mk(0,0,1,0,0,6'b110101,0,0,0,0,0,0));
    r_ent('h00, mk(0,0,1,1,0,6'b100000,0,0,0,0,0,0));
    r_ent('h02, mk(0,0,1,1,0,6'b100001,0,0,0,0,0,0));
    r_ent('h03, mk(0,0,1,1,0,6'b100011,0,0,0,0,0,0));
    r_ent('h08, mk(3,0,0,0,0,6'b000000,0,0,0,0,0,0));
    r_ent('h09, mk(3,0,1,0,0,6'b000000,0,0,0,2,0,0));
    i_ent('h08, mk(0,1,1,0,1,6'b000000,1,0,0,0,1,0));
    i_ent('h09, mk(0,1,1,0,1,6'b000000,0,0,0,0,1,0));
    i_ent('h0C, mk(0,1,1,0,1,6'b011000,0,0,0,0,0,0));
    i_ent('h0A, mk(0,1,1,0,1,6'b110101,1,0,0,0,1,0));
    i_ent('h0B, mk(0,1,1,0,1,6'b110101,0,0,0,0,1,0));
    i_ent('h0F, mk(0,1,1,0,1,6'b000000,0,0,0,0,0,1));
    i_ent('h23, mk(0,1,1,0,1,6'b000000,0,1,0,1,1,0));
    i_ent('h2B, mk(0,1,0,0,1,6'b000000,0,0,1,0,1,0));
    i_ent('h04, mk(1,0,0,0,0,6'b110011,1,0,0,0,1,0));
    i_ent('h05, mk(1,0,0,0,0,6'b110001,1,0,0,0,1,0));
    i_ent('h06, mk(1,0,0,0,0,6'b111101,1,0,0,0,1,0));
    i_ent('h07, mk(1,0,0,0,0,6'b111111,1,0,0,0,1,0));
    i_ent('h01, mk(1,0,0,0,0,6'b111011,1,0,0,0,1,0));
    i_ent('h02, mk(2,0,0,0,0,6'b000000,0,0,0,0,0,0));
    i_ent('h03, mk(2,2,1,0,0,6'b000000,0,0,0,2,0,0));
  end

  function automatic exp_t model(logic [31:0] ins, bit pnd, bit sup);
    int  o = int'(ins[31:26]);
    int  f = int'(ins[5:0]);
    bit  ok = (o == 0) ? rok[f] : iok[o];
    if (pnd && !sup) return mk(5,3,1,0,0,6'b0,0,0,0,2,0,0);
    if (!ok) return sup ? exp_t'(0) : mk(4,3,1,0,0,6'b0,0,0,0,2,0,0);
    return (o == 0) ? rtab[f] : itab[o];
  endfunction

  // Called just after a rising edge: advance the pending model over that
  // edge, apply new inputs, and queue the response expected this cycle.
  task automatic step(logic [31:0] ins, bit irq, bit sup, bit rst);
    item_t it;
    pend = prev_rst ? 1'b0 : (prev_irq | (pend & prev_sup));
    reset = rst; instruction = ins; IRQ = irq; Supervise = sup;
    if (rst) pend = 0;
    it.e = model(ins, pend, sup); it.ins = ins; it.id = issued++;
    q.push_back(it);
    prev_irq = irq; prev_sup = sup; prev_rst = rst;
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    item_t it;
    exp_t  act;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        it  = q.pop_front();
        act = {PCSrc, RegDst, RegWr, ALUSrc1, ALUSrc2, ALUFun, Sign, MemRd, MemWr,
               MemToReg, EXTOp, LUOp};
        tests++;
        if (act !== it.e) begin
          fails++;
          $display("FAIL decode#%0d ins=%08h got=%06h want=%06h", it.id, it.ins, act, it.e);
        end
      end
    end
  end

  logic [31:0] rins;
  initial begin : driver
    @(posedge clk); #1;
    step(32'h0000_0000, 1, 0, 1);  // reset held: IRQ must not pend
    step(32'h0000_0000, 0, 0, 0);
    step(32'h03FF_FFE0, 0, 0, 0);
    step(32'h23FF_FFC0, 0, 0, 0);
    step(32'h0FFF_FFC0, 0, 0, 0);
    step(32'hFFFF_FFC0, 0, 0, 0);
    step(32'hFFFF_FFC0, 0, 1, 0);
    step(32'h0000_0025, 0, 0, 0);
    step(32'h0000_0024, 0, 0, 0);
    // one-cycle IRQ pulse in user mode
    step(32'h0000_0000, 1, 0, 0);
    step(32'h03FF_FFE0, 0, 0, 0);
    step(32'h03FF_FFE0, 0, 0, 0);
    // IRQ while in kernel mode is held until Supervise drops
    step(32'h23FF_FFC0, 1, 1, 0);
    step(32'hFFFF_FFC0, 0, 1, 0);
    step(32'h23FF_FFC0, 0, 1, 0);
    step(32'h23FF_FFC0, 0, 0, 0);
    step(32'h23FF_FFC0, 0, 0, 0);
    // reset mid-operation clears a pending request immediately
    step(32'h0000_0000, 1, 0, 0);
    step(32'h0FFF_FFC0, 0, 0, 1);
    step(32'h0FFF_FFC0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      int r = $urandom_range(0, 9);
      rins = $urandom;
      if (r < 4) begin
        rins[31:26] = 6'h00;
        do rins[5:0] = 6'($urandom_range(0, 63)); while (!rok[int'(rins[5:0])]);
      end else if (r < 7) begin
        do rins[31:26] = 6'($urandom_range(1, 63)); while (!iok[int'(rins[31:26])]);
      end
      step(rins, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0);
    end
    for (int w = 0; w < 20 && q.size() != 0; w++) @(posedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
